// File: rtl/adxl345_sample_unpacker_pkg.sv
// Shared definitions for the ADXL345 sample unpacker: FSM states and frame byte order.
package adxl345_sample_unpacker_pkg;

   typedef enum logic [1:0] {
      COLLECT   = 2'd0,
      PUBLISH   = 2'd1,
      WAIT_DONE = 2'd2
   } state_t;

   localparam int unsigned BYTES_PER_FRAME = 6;

   // Byte position of each register within one SPI burst read
   localparam logic [2:0] IDX_X0 = 3'd0;
   localparam logic [2:0] IDX_X1 = 3'd1;
   localparam logic [2:0] IDX_Y0 = 3'd2;
   localparam logic [2:0] IDX_Y1 = 3'd3;
   localparam logic [2:0] IDX_Z0 = 3'd4;
   localparam logic [2:0] IDX_Z1 = 3'd5;

endpackage

// File: rtl/adxl345_axis_sext.sv
// Sign-extends the low RES_BITS of a raw 16-bit axis word to DATA_WIDTH bits.
module adxl345_axis_sext #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned RES_BITS   = 10
) (
   input  logic [15:0]                   raw,
   output logic signed [DATA_WIDTH-1:0]  sext
);

   localparam int unsigned SHIFT = 16 - RES_BITS;

   logic signed [15:0] aligned;
   logic signed [15:0] ext16;

   // Left-justify the significant bits, then arithmetic-shift back to replicate the sign bit
   assign aligned = $signed(raw << SHIFT);
   assign ext16   = aligned >>> SHIFT;
   assign sext    = DATA_WIDTH'(ext16);

endmodule

// File: rtl/adxl345_sample_unpacker.sv
// Assembles six SPI data bytes into signed X/Y/Z samples and holds them until the filters finish.
module adxl345_sample_unpacker
   import adxl345_sample_unpacker_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 16,
   parameter int unsigned RES_BITS     = 10,
   parameter int unsigned DONE_TIMEOUT = 15
) (
   input  logic                         clk,
   input  logic                         i_rstn,
   input  logic                         i_byte_val,
   input  logic [7:0]                   i_byte,
   input  logic                         i_frame_start,
   input  logic                         i_filt_done,
   output logic signed [DATA_WIDTH-1:0] o_x,
   output logic signed [DATA_WIDTH-1:0] o_y,
   output logic signed [DATA_WIDTH-1:0] o_z,
   output logic                         o_dataval,
   output logic                         o_busy,
   output logic                         o_frame_err,
   output logic [15:0]                  o_frame_cnt
);

   localparam int unsigned TCNT_W = $clog2(DONE_TIMEOUT + 1);

   state_t              state, state_n;
   logic [2:0]          idx, idx_n;
   logic [TCNT_W-1:0]   tcnt, tcnt_n;
   logic                store;
   logic [2:0]          store_idx;
   logic                err_n;
   logic                publish;
   logic                release_busy;
   logic [7:0]          frame_bytes [BYTES_PER_FRAME];

   logic signed [DATA_WIDTH-1:0] x_ext, y_ext, z_ext;

   adxl345_axis_sext #(.DATA_WIDTH(DATA_WIDTH), .RES_BITS(RES_BITS)) u_sext_x (
      .raw  ({frame_bytes[IDX_X1], frame_bytes[IDX_X0]}),
      .sext (x_ext)
   );

   adxl345_axis_sext #(.DATA_WIDTH(DATA_WIDTH), .RES_BITS(RES_BITS)) u_sext_y (
      .raw  ({frame_bytes[IDX_Y1], frame_bytes[IDX_Y0]}),
      .sext (y_ext)
   );

   adxl345_axis_sext #(.DATA_WIDTH(DATA_WIDTH), .RES_BITS(RES_BITS)) u_sext_z (
      .raw  ({frame_bytes[IDX_Z1], frame_bytes[IDX_Z0]}),
      .sext (z_ext)
   );

   // Next-state, byte-capture and error decisions
   always_comb begin
      state_n      = state;
      idx_n        = idx;
      tcnt_n       = tcnt;
      store        = 1'b0;
      store_idx    = idx;
      err_n        = 1'b0;
      publish      = 1'b0;
      release_busy = 1'b0;
      case (state)
         COLLECT: begin
            if (i_byte_val) begin
               if (i_frame_start) begin
                  // A frame start mid-frame abandons the partial frame and restarts at DATAX0
                  store     = 1'b1;
                  store_idx = IDX_X0;
                  idx_n     = IDX_X1;
                  err_n     = (idx != IDX_X0);
               end else if (idx == IDX_X0) begin
                  err_n = 1'b1;
               end else begin
                  store = 1'b1;
                  if (idx == IDX_Z1) begin
                     idx_n   = IDX_X0;
                     state_n = PUBLISH;
                  end else begin
                     idx_n = idx + 3'd1;
                  end
               end
            end
         end
         PUBLISH: begin
            publish = 1'b1;
            err_n   = i_byte_val;
            tcnt_n  = '0;
            state_n = WAIT_DONE;
         end
         WAIT_DONE: begin
            err_n = i_byte_val;
            if (i_filt_done) begin
               state_n      = COLLECT;
               release_busy = 1'b1;
               tcnt_n       = '0;
            end else if (tcnt == TCNT_W'(DONE_TIMEOUT - 1)) begin
               state_n      = COLLECT;
               release_busy = 1'b1;
               err_n        = 1'b1;
               tcnt_n       = '0;
            end else begin
               tcnt_n = tcnt + 1'b1;
            end
         end
         default: begin
            state_n = COLLECT;
            idx_n   = IDX_X0;
            tcnt_n  = '0;
         end
      endcase
   end

   // State, byte storage and registered outputs
   always_ff @(posedge clk) begin
      if (!i_rstn) begin
         state       <= COLLECT;
         idx         <= IDX_X0;
         tcnt        <= '0;
         o_x         <= '0;
         o_y         <= '0;
         o_z         <= '0;
         o_dataval   <= 1'b0;
         o_busy      <= 1'b0;
         o_frame_err <= 1'b0;
         o_frame_cnt <= '0;
         for (int unsigned i = 0; i < BYTES_PER_FRAME; i++) begin
            frame_bytes[i] <= '0;
         end
      end else begin
         state       <= state_n;
         idx         <= idx_n;
         tcnt        <= tcnt_n;
         o_frame_err <= err_n;
         o_dataval   <= publish;
         if (store) begin
            frame_bytes[store_idx] <= i_byte;
         end
         if (publish) begin
            o_x         <= x_ext;
            o_y         <= y_ext;
            o_z         <= z_ext;
            o_frame_cnt <= o_frame_cnt + 16'd1;
            o_busy      <= 1'b1;
         end else if (release_busy) begin
            o_busy <= 1'b0;
         end
      end
   end

endmodule
